// File: rtl/ic_fsm_param.sv
// ic_fsm_param: instruction-cache control FSM.
// It evaluates each fetch as a hit or a miss. A miss runs a LINE_WORDS-beat refill burst.
// A cache-inhibited access is a single BIU read with no RAM or tag write.
// Build option ICFSM_CWF_EN: when defined, the refill is critical-word-first.
// When it is not defined, the refill is line-aligned and starts at word 0.
module ic_fsm_param #(
    parameter int unsigned AW         = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TAG_LSB    = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ic_en,
    input  logic                          icqmem_cycstb_i,
    input  logic                          icqmem_ci_i,
    input  logic [AW-1:0]                 start_addr,
    input  logic                          tagcomp_miss,
    input  logic                          biudata_valid,
    input  logic                          biudata_error,
    output logic [AW-1:0]                 saved_addr,
    output logic                          biu_read,
    output logic                          burst,
    output logic [3:0]                    icram_we,
    output logic                          tag_we,
    output logic                          first_hit_ack,
    output logic                          first_miss_ack,
    output logic                          first_miss_err,
    output logic                          refill_done,
    output logic [$clog2(LINE_WORDS)-1:0] word_idx
);

    localparam int unsigned CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] IdxOne  = CW'(1);
    localparam logic [CW-1:0] CntLoad = CW'(LINE_WORDS - 2);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLookup = 2'd1,
        StRefill = 2'd2
    } state_e;

    state_e          r_state, w_state_d;
    logic [AW-1:0]   r_saved_addr, w_saved_addr_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;
    logic [CW-1:0]   r_req_off, w_req_off_d;
    logic            r_hitmiss_eval, w_hitmiss_eval_d;
    logic            r_load, w_load_d;
    logic            r_cache_inhibit, w_cache_inhibit_d;
    logic            r_acked, w_acked_d;
    logic            w_lookup, w_refill, w_abort;
`ifndef ICFSM_CWF_EN
    logic            w_line_miss;
`endif

    assign w_lookup = (r_state == StLookup);
    assign w_refill = (r_state == StRefill);
    assign word_idx = saved_addr[CW+1:2];

    // BIU address: line-aligned refill presents word 0 as soon as a line miss is seen
    always_comb begin
        saved_addr = r_saved_addr;
`ifndef ICFSM_CWF_EN
        w_line_miss = w_lookup & tagcomp_miss & ~r_cache_inhibit & ~icqmem_ci_i;
        if (w_line_miss) begin
            saved_addr[CW+1:2] = '0;
        end
`endif
    end

    // Combinational handshake outputs toward BIU, data/tag RAMs and the fetch port
    always_comb begin
        biu_read       = (r_hitmiss_eval & tagcomp_miss) | (~r_hitmiss_eval & r_load);
        tag_we         = biu_read & biudata_valid & ~r_cache_inhibit;
        icram_we       = {4{tag_we}};
        first_hit_ack  = w_lookup & r_hitmiss_eval & ~tagcomp_miss & ~r_cache_inhibit &
                         ~icqmem_ci_i;
        first_miss_ack = (w_lookup | w_refill) & biudata_valid & ~r_acked &
                         (word_idx == r_req_off);
        first_miss_err = (w_lookup | w_refill) & biudata_error;
        burst          = (w_lookup & tagcomp_miss & ~r_cache_inhibit) | w_refill;
        refill_done    = w_refill & biudata_valid & ~biudata_error & (r_cnt == '0);
    end

    // Next-state logic for the FSM and its bookkeeping registers
    always_comb begin
        w_state_d         = r_state;
        w_saved_addr_d    = r_saved_addr;
        w_cnt_d           = r_cnt;
        w_req_off_d       = r_req_off;
        w_hitmiss_eval_d  = r_hitmiss_eval;
        w_load_d          = r_load;
        w_cache_inhibit_d = r_cache_inhibit;
        w_acked_d         = r_acked | first_miss_ack;
        w_abort           = ~ic_en | (r_hitmiss_eval & ~icqmem_cycstb_i) | biudata_error |
                            (r_cache_inhibit & biudata_valid);

        unique case (r_state)
            StIdle: begin
                if (ic_en & icqmem_cycstb_i) begin
                    w_state_d         = StLookup;
                    w_saved_addr_d    = start_addr;
                    w_req_off_d       = start_addr[CW+1:2];
                    w_hitmiss_eval_d  = 1'b1;
                    w_load_d          = 1'b1;
                    w_acked_d         = 1'b0;
                    w_cache_inhibit_d = 1'b0;
                end else begin
                    w_hitmiss_eval_d  = 1'b0;
                    w_load_d          = 1'b0;
                    w_cache_inhibit_d = 1'b0;
                end
            end
            StLookup: begin
                if (icqmem_cycstb_i & icqmem_ci_i) begin
                    w_cache_inhibit_d = 1'b1;
                end
                // The tag part follows the fetch port while the hit is still being judged
                if (r_hitmiss_eval) begin
                    w_saved_addr_d[AW-1:TAG_LSB] = start_addr[AW-1:TAG_LSB];
                end
                if (w_abort) begin
                    w_state_d         = StIdle;
                    w_hitmiss_eval_d  = 1'b0;
                    w_load_d          = 1'b0;
                    w_cache_inhibit_d = 1'b0;
                end else if (tagcomp_miss & biudata_valid & ~r_cache_inhibit) begin
                    // First beat is written now; step to the next word of the line
                    w_state_d                = StRefill;
                    w_saved_addr_d[CW+1:2]   = word_idx + IdxOne;
                    w_cnt_d                  = CntLoad;
                    w_hitmiss_eval_d         = 1'b0;
                end else if (~tagcomp_miss & ~icqmem_ci_i) begin
                    w_saved_addr_d = start_addr;
                    w_req_off_d    = start_addr[CW+1:2];
                end else if (~icqmem_cycstb_i) begin
                    w_state_d         = StIdle;
                    w_hitmiss_eval_d  = 1'b0;
                    w_load_d          = 1'b0;
                    w_cache_inhibit_d = 1'b0;
                end else begin
                    w_hitmiss_eval_d = 1'b0;
`ifndef ICFSM_CWF_EN
                    if (w_line_miss) begin
                        w_saved_addr_d[CW+1:2] = '0;
                    end
`endif
                end
            end
            StRefill: begin
                if (biudata_error) begin
                    w_state_d         = StIdle;
                    w_hitmiss_eval_d  = 1'b0;
                    w_load_d          = 1'b0;
                    w_cache_inhibit_d = 1'b0;
                end else if (biudata_valid) begin
                    if (r_cnt != '0) begin
                        w_cnt_d                = r_cnt - IdxOne;
                        w_saved_addr_d[CW+1:2] = r_saved_addr[CW+1:2] + IdxOne;
                    end else begin
                        w_state_d         = StIdle;
                        w_saved_addr_d    = start_addr;
                        w_hitmiss_eval_d  = 1'b0;
                        w_load_d          = 1'b0;
                        w_cache_inhibit_d = 1'b0;
                    end
                end
            end
            default: begin
                w_state_d         = StIdle;
                w_hitmiss_eval_d  = 1'b0;
                w_load_d          = 1'b0;
                w_cache_inhibit_d = 1'b0;
            end
        endcase
    end

    // State and bookkeeping registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= StIdle;
            r_saved_addr    <= '0;
            r_cnt           <= '0;
            r_req_off       <= '0;
            r_hitmiss_eval  <= 1'b0;
            r_load          <= 1'b0;
            r_cache_inhibit <= 1'b0;
            r_acked         <= 1'b0;
        end else begin
            r_state         <= w_state_d;
            r_saved_addr    <= w_saved_addr_d;
            r_cnt           <= w_cnt_d;
            r_req_off       <= w_req_off_d;
            r_hitmiss_eval  <= w_hitmiss_eval_d;
            r_load          <= w_load_d;
            r_cache_inhibit <= w_cache_inhibit_d;
            r_acked         <= w_acked_d;
        end
    end

endmodule

// File: tb/tb_ic_fsm_param.sv
// Testbench for ic_fsm_param with LINE_WORDS=8.
// Stimulus pushes the expected output events into a queue.
// A monitor compares each DUT event against the head of that queue.
module tb_ic_fsm_param;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 3;
`ifdef ICFSM_CWF_EN
    localparam int unsigned Base = 5;
`else
    localparam int unsigned Base = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_en = 1'b0, cyc = 1'b0, ci = 1'b0, miss = 1'b0;
    logic          valid = 1'b0, err = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [AW-1:0] saved_addr;
    logic          biu_read, burst, tag_we, first_hit_ack, first_miss_ack, first_miss_err;
    logic          refill_done;
    logic [3:0]    icram_we;
    logic [CW-1:0] word_idx;

    ic_fsm_param #(.AW(AW), .LINE_WORDS(LW), .TAG_LSB(13)) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_en          (ic_en),
        .icqmem_cycstb_i(cyc),
        .icqmem_ci_i    (ci),
        .start_addr     (addr),
        .tagcomp_miss   (miss),
        .biudata_valid  (valid),
        .biudata_error  (err),
        .saved_addr     (saved_addr),
        .biu_read       (biu_read),
        .burst          (burst),
        .icram_we       (icram_we),
        .tag_we         (tag_we),
        .first_hit_ack  (first_hit_ack),
        .first_miss_ack (first_miss_ack),
        .first_miss_err (first_miss_err),
        .refill_done    (refill_done),
        .word_idx       (word_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hit;
        logic          mack;
        logic          merr;
        logic          we;
        logic          done;
        logic          burst;
        logic          rd;
        logic [CW-1:0] idx;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Monitor: any strobe/ack cycle is an event, compared against the queue head
    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        if (!rst && (tag_we | first_hit_ack | first_miss_ack | first_miss_err | refill_done)) begin
            act = {first_hit_ack, first_miss_ack, first_miss_err, tag_we, refill_done, burst,
                   biu_read, word_idx};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event t=%0t act=%h", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e || icram_we !== {4{e.we}}) begin
                    n_bad++;
                    $display("FAIL event t=%0t act=%h we4=%h exp=%h", $time, act, icram_we, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic hit, input logic mack, input logic merr, input logic we,
                        input logic done, input logic bst, input logic rd, input int unsigned idx);
        ev_t e;
        e = {hit, mack, merr, we, done, bst, rd, CW'(idx)};
        exp_q.push_back(e);
    endtask

    // Refill beat k (0-based) of the miss at 0x2014, whose requested word is 5
    task automatic push_beat(input int unsigned k);
        int unsigned idx;
        idx = (Base + k) % LW;
        push(1'b0, idx == 5, 1'b0, 1'b1, k == LW - 1, 1'b1, 1'b1, idx);
    endtask

    function automatic logic [63:0] outs();
        return 64'({biu_read, burst, icram_we, tag_we, first_hit_ack, first_miss_ack,
                    first_miss_err, refill_done});
    endfunction

    // Accept a miss at 0x2014, wait one LOOKUP cycle, then deliver the first beat
    task automatic start_miss();
        ic_en = 1'b1; cyc = 1'b1; ci = 1'b0; addr = 32'h2014; miss = 1'b1;
        step();
        step();
        valid = 1'b1;
        push_beat(0);
        step();
    endtask

    initial begin
        step();
        step();
        check("reset_outs", outs(), 64'd0);
        check("reset_addr", 64'(saved_addr), 64'd0);
        rst = 1'b0;
        step();

        // Hit, back-to-back hit, then drop the request
        ic_en = 1'b1; cyc = 1'b1; addr = 32'h1000; miss = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        addr = 32'h1004;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step();
        step();
        cyc = 1'b0; miss = 1'b1;
        step();
        miss = 1'b0;
        #3 check("hit_idle_outs", outs(), 64'd0);

        // Full refill with one BIU wait state
        step();
        start_miss();
        for (int k = 1; k < LW; k++) begin
            if (k == 3) begin
                valid = 1'b0;
                step();
                valid = 1'b1;
            end
            push_beat(k);
            step();
        end
        valid = 1'b0; cyc = 1'b0; miss = 1'b0;
        #3 check("refill_idle_outs", outs(), 64'd0);
        check("refill_saved_addr", 64'(saved_addr), 64'h2014);

        // Bus error on the third beat
        step();
        start_miss();
        push_beat(1);
        step();
        valid = 1'b0; err = 1'b1;
        push(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, (Base + 2) % LW);
        step();
        err = 1'b0; cyc = 1'b0; miss = 1'b0;
        #3 check("err_idle_outs", outs(), 64'd0);
        step();
        step();

        // Cache-inhibited single read at 0x3008
        ic_en = 1'b1; cyc = 1'b1; ci = 1'b1; addr = 32'h3008; miss = 1'b1;
        step();
        step();
        valid = 1'b1;
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        step();
        valid = 1'b0; cyc = 1'b0; ci = 1'b0; miss = 1'b0;
        #3 check("ci_idle_outs", outs(), 64'd0);

        // Asynchronous reset after two refill beats
        step();
        start_miss();
        push_beat(1);
        step();
        valid = 1'b0; cyc = 1'b0; miss = 1'b0;
        #2 rst = 1'b1;
        #1 check("rst_outs", outs(), 64'd0);
        check("rst_addr", 64'(saved_addr), 64'd0);
        check("rst_idx", 64'(word_idx), 64'd0);
        step();
        rst = 1'b0;
        step();
        #3 check("post_rst_outs", outs(), 64'd0);
        step();
        ic_en = 1'b1; cyc = 1'b1; addr = 32'h1008; miss = 1'b0;
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        step();
        step();
        cyc = 1'b0; miss = 1'b1;
        step();
        miss = 1'b0;
        step();
        step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
